div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the multi-cycle radix-2 divider (`div`).
- Accepts DIV/DIVU/REM/REMU requests from EX and registers the operands. Holds the divider's start level for the full iteration and stalls the pipeline.
- Captures the result, presents it for one cycle, and aborts cleanly on pipeline flush.
- Handles divide-by-zero and a watchdog timeout without running the divider.

Parameters:
- XLEN, 32, datapath width (matches `XLEN).
- DIV_TIMEOUT, 40, maximum RUN cycles without div_done_i before forced abort.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pipe_flush  in  1  flush EX; abort any operation
- ex_div_req  in  1  EX holds a valid div/rem instruction; held until ex_div_valid
- ex_div_sign  in  1  1 = signed (DIV/REM)
- ex_div_res_sel  in  1  `REMAINDER selects remainder, else quotient
- ex_rs1  in  XLEN  dividend
- ex_rs2  in  XLEN  divisor
- ex_div_stall  out  1  stall request to pipeline control
- ex_div_valid  out  1  result valid, one-cycle pulse
- ex_div_res  out  XLEN  result
- ex_div_err  out  1  timeout abort, pulses with ex_div_valid
- div_start_o  out  1  to divider ex_is_div_inst, level
- div_sign_o  out  1  registered sign
- div_res_sel_o  out  1  result select to divider
- div_dividend_o  out  XLEN  registered dividend
- div_divisor_o  out  XLEN  registered divisor
- div_done_i  in  1  divider done
- div_res_i  in  XLEN  divider result

Behaviour:
- Reset: state = IDLE; every output 0 (div_res_sel_o = quotient encoding); operand registers 0; timeout counter 0.
- FSM states: IDLE, RUN, RD2 (cache build only), RESP.
- IDLE, ex_div_req & ~pipe_flush: latch rs1, rs2, sign, sel.
  - If rs2 == 0: result = all-ones (quotient) or rs1 (remainder); go to RESP without starting the divider.
  - Otherwise: go to RUN.
- RUN:
  - div_start_o = ~pipe_flush; timeout counter increments each cycle.
  - On div_done_i: capture div_res_i into the result register, then go to RESP.
  - If the counter reaches DIV_TIMEOUT-1 without done: result = all-ones, err = 1, go to RESP.
- RESP: ex_div_valid = 1, ex_div_res = result register, ex_div_err as latched; next state IDLE.
- ex_div_stall = ex_div_req & ~ex_div_valid (combinational). The pipeline advances in the RESP cycle.
- Latency, acceptance edge = cycle 0:
  - RUN occupies cycles 1..34 (divider cnt 0..33).
  - RESP at cycle 35.
  - Zero divisor: RESP at cycle 1.
- div_start_o drops in RESP. The divider's cnt returns to 0 before the next request is accepted (IDLE ≥ 1 cycle), so back-to-back requests are separated by one IDLE cycle.
- Flush, any state:
  - Next state is IDLE; div_start_o forced 0 in the flush cycle.
  - No valid/err pulse; timeout counter cleared.
  - A flush in the RESP cycle suppresses nothing: valid already issued.
- ex_div_req dropping in RUN without a flush is a protocol violation; the operation still completes and RESP is issued.
- -2^31 / -1 signed: pass through the divider result (0x8000_0000 quotient, 0 remainder). No special case.
- Operands come only from the registered copies. EX operand changes after acceptance are ignored.

Optional Feature:
- DIV_RESULT_CACHE_EN.
- Defined:
  - RUN captures the quotient (div_res_sel_o = quotient) on done.
  - RD2 (1 cycle, div_start_o = 0, div_res_sel_o = `REMAINDER) captures the remainder.
  - Stores {rs1, rs2, sign} tag, quotient, remainder, and a valid bit.
  - An IDLE request whose tag matches a valid entry goes straight to RESP (1-cycle latency) with the sel-selected value.
  - Uncached latency becomes 36.
  - Flush or timeout never writes the cache; reset clears the valid bit.
- Undefined: no RD2 state, no tag storage; div_res_sel_o = latched sel during RUN.

Decomposition:
- Shared defines: XLEN, `REMAINDER/quotient select encodings, `FLUSH, `DFF_RST_ENABLE, `RST_EDGE, FSM state encodings (2-bit).
- Sub-module div_res_cache (tag compare + quotient/remainder storage), instantiated only under DIV_RESULT_CACHE_EN.

Test Plan:
- DIVU 100/7, sel quotient -> stall for 35 cycles, ex_div_valid at cycle 35, res = 14; REMU same -> 2.
- DIV 0xFFFF_FF9C(-100)/7 -> 0xFFFF_FFF2(-14); REM -> 0xFFFF_FFFE(-2); DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000.
- DIVU 5/0 -> valid at cycle 1, res 0xFFFF_FFFF; REMU 5/0 -> 5; div_start_o never asserted.
- pipe_flush at RUN cycle 10 -> next cycle IDLE, div_start_o 0, no valid; new DIVU 9/3 afterwards -> 3 with full latency.
- Divider model never asserts done -> ex_div_valid and ex_div_err at RUN cycle 40, res 0xFFFF_FFFF.
- Cache on: DIV 100/7 (valid at 36) then REM 100/7 -> valid at cycle 1, res 2; DIVU 100/7 (sign differs) -> miss, 36 cycles.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared constants for the divider sequencing controller:
//               datapath width, result-select and flush encodings, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_ctrl_pkg;

    localparam int c_XLEN = 32;

    // Result select seen by EX and by the divider
    localparam logic c_SEL_QUOT = 1'b0;
    localparam logic c_SEL_REM  = 1'b1;

    // Active level of pipe_flush and of rst_n
    localparam logic c_FLUSH      = 1'b1;
    localparam logic c_RST_ACTIVE = 1'b0;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_RUN  = 2'b01;
    localparam logic [1:0] c_ST_RD2  = 2'b10;
    localparam logic [1:0] c_ST_RESP = 2'b11;

endpackage

`default_nettype wire

// File: rtl/div_res_cache.sv
// ============================================================================
// Module      : div_res_cache
// Description : Single-entry result cache for the divider. Tag is
//               {dividend, divisor, sign}; stores quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_res_cache
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_lookup_rs1,
    input  logic [XLEN-1:0] i_lookup_rs2,
    input  logic            i_lookup_sign,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_rs1,
    input  logic [XLEN-1:0] i_wr_rs2,
    input  logic            i_wr_sign,
    input  logic [XLEN-1:0] i_wr_quot,
    input  logic [XLEN-1:0] i_wr_rem,
    output logic            o_hit,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    logic            r_valid;
    logic [XLEN-1:0] r_tag_rs1;
    logic [XLEN-1:0] r_tag_rs2;
    logic            r_tag_sign;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ACTIVE) begin
            r_valid    <= 1'b0;
            r_tag_rs1  <= '0;
            r_tag_rs2  <= '0;
            r_tag_sign <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if (i_wr_en) begin
            r_valid    <= 1'b1;
            r_tag_rs1  <= i_wr_rs1;
            r_tag_rs2  <= i_wr_rs2;
            r_tag_sign <= i_wr_sign;
            r_quot     <= i_wr_quot;
            r_rem      <= i_wr_rem;
        end
    end

    assign o_hit  = r_valid
                  & (r_tag_rs1  == i_lookup_rs1)
                  & (r_tag_rs2  == i_lookup_rs2)
                  & (r_tag_sign == i_lookup_sign);
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : Sequencer between EX and the multi-cycle radix-2 divider.
//               Optional result cache enabled by macro DIV_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN        = c_XLEN,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            ex_div_req,
    input  logic            ex_div_sign,
    input  logic            ex_div_res_sel,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    output logic            ex_div_stall,
    output logic            ex_div_valid,
    output logic [XLEN-1:0] ex_div_res,
    output logic            ex_div_err,
    output logic            div_start_o,
    output logic            div_sign_o,
    output logic            div_res_sel_o,
    output logic [XLEN-1:0] div_dividend_o,
    output logic [XLEN-1:0] div_divisor_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_res_i
);

    localparam int                 c_TMO_W    = $clog2(DIV_TIMEOUT) + 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(DIV_TIMEOUT - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_next_state;
    logic               r_sign;
    logic               r_sel;
    logic               r_err;
    logic [XLEN-1:0]    r_dividend;
    logic [XLEN-1:0]    r_divisor;
    logic [XLEN-1:0]    r_res;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    logic w_flush;
    logic w_idle_req;
    logic w_zero_div;
    logic w_run_done;
    logic w_run_tmo;
    logic w_lookup_hit;

    assign w_flush    = (pipe_flush == c_FLUSH);
    assign w_idle_req = (r_state == c_ST_IDLE) & ex_div_req & ~w_flush;
    assign w_zero_div = (ex_rs2 == '0);
    assign w_run_done = (r_state == c_ST_RUN) & ~w_flush & div_done_i;
    // Done in the last allowed cycle still wins over the timeout
    assign w_run_tmo  = (r_state == c_ST_RUN) & ~w_flush & ~div_done_i
                      & (r_tmo_cnt == c_TMO_LAST);

`ifdef DIV_RESULT_CACHE_EN
    logic            w_rd2_cap;
    logic [XLEN-1:0] w_hit_quot;
    logic [XLEN-1:0] w_hit_rem;
    logic [XLEN-1:0] r_quot;

    assign w_rd2_cap = (r_state == c_ST_RD2) & ~w_flush;

    div_res_cache #(
        .XLEN (XLEN)
    ) u_res_cache (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lookup_rs1  (ex_rs1),
        .i_lookup_rs2  (ex_rs2),
        .i_lookup_sign (ex_div_sign),
        .i_wr_en       (w_rd2_cap),
        .i_wr_rs1      (r_dividend),
        .i_wr_rs2      (r_divisor),
        .i_wr_sign     (r_sign),
        .i_wr_quot     (r_quot),
        .i_wr_rem      (div_res_i),
        .o_hit         (w_lookup_hit),
        .o_quot        (w_hit_quot),
        .o_rem         (w_hit_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ACTIVE) begin
            r_quot <= '0;
        end else if (w_run_done) begin
            r_quot <= div_res_i;
        end
    end
`else
    assign w_lookup_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ACTIVE) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_flush) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ex_div_req) begin
                        if (w_zero_div || w_lookup_hit) begin
                            w_next_state = c_ST_RESP;
                        end else begin
                            w_next_state = c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (div_done_i) begin
`ifdef DIV_RESULT_CACHE_EN
                        w_next_state = c_ST_RD2;
`else
                        w_next_state = c_ST_RESP;
`endif
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        w_next_state = c_ST_RESP;
                    end
                end
`ifdef DIV_RESULT_CACHE_EN
                c_ST_RD2:  w_next_state = c_ST_RESP;
`endif
                c_ST_RESP: w_next_state = c_ST_IDLE;
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ex_div_valid = 1'b0;
        ex_div_res   = '0;
        ex_div_err   = 1'b0;
        div_start_o  = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        div_res_sel_o = c_SEL_QUOT;
`else
        div_res_sel_o = r_sel;
`endif
        case (r_state)
            c_ST_RUN: begin
                div_start_o = ~w_flush;
            end
`ifdef DIV_RESULT_CACHE_EN
            c_ST_RD2: begin
                div_res_sel_o = c_SEL_REM;
            end
`endif
            c_ST_RESP: begin
                ex_div_valid = 1'b1;
                ex_div_res   = r_res;
                ex_div_err   = r_err;
            end
            default: ;
        endcase
    end

    assign ex_div_stall   = ex_div_req & ~ex_div_valid;
    assign div_sign_o     = r_sign;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ACTIVE) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sign     <= 1'b0;
            r_sel      <= c_SEL_QUOT;
            r_res      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_idle_req) begin
                r_dividend <= ex_rs1;
                r_divisor  <= ex_rs2;
                r_sign     <= ex_div_sign;
                r_sel      <= ex_div_res_sel;
                r_err      <= 1'b0;
                // Divide-by-zero bypasses the divider with the ISA-defined result
                if (w_zero_div) begin
                    r_res <= (ex_div_res_sel == c_SEL_REM) ? ex_rs1 : '1;
                end
`ifdef DIV_RESULT_CACHE_EN
                else if (w_lookup_hit) begin
                    r_res <= (ex_div_res_sel == c_SEL_REM) ? w_hit_rem : w_hit_quot;
                end
`endif
            end
            if (w_run_tmo) begin
                r_res <= '1;
                r_err <= 1'b1;
            end
`ifdef DIV_RESULT_CACHE_EN
            if (w_rd2_cap) begin
                r_res <= (r_sel == c_SEL_REM) ? div_res_i : r_quot;
            end
`else
            if (w_run_done) begin
                r_res <= div_res_i;
            end
`endif
        end
    end

    // Counts RUN cycles; cleared whenever the FSM is not staying in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == c_RST_ACTIVE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_ST_RUN) && (w_next_state == c_ST_RUN)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

endmodule

`default_nettype wire
